// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: accepts exceptions, interrupts, mret and wfi, then updates mepc/mcause/mstatus and redirects the PC.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt entry when mtvec[1:0] == 2'b01.
module trap_ctrl #(
  parameter int unsigned IRQ_NUM = 4,
  parameter int unsigned PC_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_i,
  input  logic               ecall_i,
  input  logic               ebreak_i,
  input  logic               inst_err_i,
  input  logic               mret_i,
  input  logic               wfi_i,
  input  logic [IRQ_NUM-1:0] irq_ext_i,
  input  logic               irq_soft_i,
  input  logic               irq_tcmp_i,
  input  logic [PC_W-1:0]    csr_rdata_i,
  output logic [PC_W-1:0]    csr_wdata_o,
  output logic               csr_we_o,
  output logic [11:0]        csr_addr_o,
  output logic               trap_in_o,
  output logic               jump_o,
  output logic [PC_W-1:0]    jump_addr_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [PC_W-1:0] INT_FLAG = {1'b1, {(PC_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MEPC, MCAUSE, MSTAT, JUMP, MRET, MRETJ, WFI} state_t;

  state_t          state;
  state_t          acc_state;
  logic            accept;
  logic [PC_W-1:0] acc_cause;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] cause_q;
  logic            ext_hit;
  logic [3:0]      ext_idx;
  logic [4:0]      irq_code;
  logic            irq_any;
  logic            mie;
  logic [PC_W-1:0] base;
  logic [PC_W-1:0] trap_target;
  logic [PC_W-1:0] mstat_trap;
  logic [PC_W-1:0] mstat_ret;

  // Lowest-index external interrupt wins.
  always_comb begin
    ext_hit = 1'b0;
    ext_idx = 4'd0;
    for (int k = int'(IRQ_NUM) - 1; k >= 0; k--) begin
      if (irq_ext_i[k]) begin
        ext_hit = 1'b1;
        ext_idx = 4'(k);
      end
    end
  end

  assign irq_any  = ext_hit | irq_soft_i | irq_tcmp_i;
  assign irq_code = ext_hit ? (5'd16 | 5'(ext_idx)) : (irq_soft_i ? 5'd3 : 5'd7);
  // csr_addr_o is mstatus while idle, so bit 3 of the read data is MIE.
  assign mie      = csr_rdata_i[3];

  always_comb begin
    accept    = 1'b0;
    acc_state = MEPC;
    acc_cause = '0;
    if (inst_err_i) begin
      accept    = 1'b1;
      acc_cause = PC_W'(2);
    end else if (ecall_i) begin
      accept    = 1'b1;
      acc_cause = PC_W'(11);
    end else if (ebreak_i) begin
      accept    = 1'b1;
      acc_cause = PC_W'(3);
    end else if (mret_i) begin
      accept    = 1'b1;
      acc_state = MRET;
    end else if (wfi_i) begin
      accept    = 1'b1;
      acc_state = WFI;
    end else if (mie && irq_any) begin
      accept    = 1'b1;
      acc_cause = INT_FLAG | PC_W'(irq_code);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= acc_state;
            pc_q    <= pc_i;
            cause_q <= acc_cause;
          end
        end
        MEPC:    state <= MCAUSE;
        MCAUSE:  state <= MSTAT;
        MSTAT:   state <= JUMP;
        JUMP:    state <= IDLE;
        MRET:    state <= MRETJ;
        MRETJ:   state <= IDLE;
        WFI:     if (irq_any) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Address depends only on state so the external CSR read path has no loop.
  always_comb begin
    csr_addr_o = 12'h000;
    if (!rst) begin
      case (state)
        IDLE, MSTAT, MRET: csr_addr_o = CSR_MSTATUS;
        MEPC, MRETJ:       csr_addr_o = CSR_MEPC;
        MCAUSE:            csr_addr_o = CSR_MCAUSE;
        JUMP:              csr_addr_o = CSR_MTVEC;
        default:           csr_addr_o = 12'h000;
      endcase
    end
  end

  always_comb begin
    mstat_trap        = csr_rdata_i;
    mstat_trap[7]     = csr_rdata_i[3];
    mstat_trap[3]     = 1'b0;
    mstat_trap[12:11] = 2'b11;
    mstat_ret         = csr_rdata_i;
    mstat_ret[3]      = csr_rdata_i[7];
    mstat_ret[7]      = 1'b1;
  end

  always_comb begin
    base        = {csr_rdata_i[PC_W-1:2], 2'b00};
    trap_target = base;
`ifdef TRAP_VECTORED_EN
    if (cause_q[PC_W-1] && (csr_rdata_i[1:0] == 2'b01)) begin
      trap_target = base + PC_W'({cause_q[4:0], 2'b00});
    end
`endif
  end

  always_comb begin
    csr_we_o    = 1'b0;
    csr_wdata_o = '0;
    trap_in_o   = 1'b0;
    jump_o      = 1'b0;
    jump_addr_o = '0;
    if (!rst) begin
      case (state)
        IDLE: trap_in_o = accept;
        MEPC: begin
          trap_in_o   = 1'b1;
          csr_we_o    = 1'b1;
          csr_wdata_o = pc_q;
        end
        MCAUSE: begin
          trap_in_o   = 1'b1;
          csr_we_o    = 1'b1;
          csr_wdata_o = cause_q;
        end
        MSTAT: begin
          trap_in_o   = 1'b1;
          csr_we_o    = 1'b1;
          csr_wdata_o = mstat_trap;
        end
        JUMP: begin
          trap_in_o   = 1'b1;
          jump_o      = 1'b1;
          jump_addr_o = trap_target;
        end
        MRET: begin
          trap_in_o   = 1'b1;
          csr_we_o    = 1'b1;
          csr_wdata_o = mstat_ret;
        end
        MRETJ: begin
          trap_in_o   = 1'b1;
          jump_o      = 1'b1;
          jump_addr_o = csr_rdata_i;
        end
        WFI:     trap_in_o = 1'b1;
        default: trap_in_o = 1'b0;
      endcase
    end
  end

endmodule
